apb_exe_seq_master: RTL and testbench
=====================================

Name: apb_exe_seq_master

Overview:
APB master that sequences one execution-unit slave through a complete operation. It accepts a command (oper, argA, argB) on a valid/ready interface and issues three APB writes: oper to address 0, argA to address 1, argB to address 2. It then waits a fixed settle time and issues two APB reads: result from address 0, status from address 1. The result, status and an error flag are returned on a valid/ready response interface. It sits between a local command source and the exe-unit APB slave, and is the only master on that APB segment.

Parameters:
DATA_WIDTH, 8, width of PWDATA/PRDATA and of oper/argA/argB/result; must be >= 4.
ADDR_WIDTH, 16, width of PADDR.
EXE_LATENCY, 2, idle cycles between completion of the last write and the first read setup; 0 means no WAIT state.
TIMEOUT, 16, maximum ACCESS-phase cycles with PREADY low before the transfer is aborted; must be >= 2.

Ports:
i_PCLK  in  1  clock
i_PRESETn  in  1  reset, asynchronous assert, active-low
i_req_valid  in  1  command valid
o_req_ready  out  1  command accepted when valid and ready are both high
i_oper  in  DATA_WIDTH  operation code
i_argA  in  DATA_WIDTH  operand A
i_argB  in  DATA_WIDTH  operand B
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed
o_result  out  DATA_WIDTH  result read from address 0
o_status  out  4  status read from address 1, taken from PRDATA[3:0]
o_err  out  1  operation aborted (PSLVERR or timeout)
o_PADDR  out  ADDR_WIDTH  APB address
o_PSEL  out  1  APB select
o_PENABLE  out  1  APB enable
o_PWRITE  out  1  APB direction, 1 = write
o_PWDATA  out  DATA_WIDTH  APB write data
i_PREADY  in  1  APB ready
i_PRDATA  in  DATA_WIDTH  APB read data
i_PSLVERR  in  1  APB slave error

Behaviour:
- One clock; reset is asynchronous and active-low (i_PCLK, i_PRESETn).
- Reset values:
  - State IDLE, step = 0.
  - o_PSEL, o_PENABLE, o_PWRITE = 0; o_PADDR, o_PWDATA = 0.
  - o_rsp_valid, o_err = 0; o_result, o_status = 0.
  - o_req_ready = 1 (decoded from IDLE).
- All APB outputs are registered.
- States: IDLE, SETUP, ACCESS, WAIT, RESP. A step counter (0..4) selects the transfer:
  - step 0: write oper, address 0
  - step 1: write argA, address 1
  - step 2: write argB, address 2
  - step 3: read result, address 0
  - step 4: read status, address 1
- IDLE:
  - o_req_ready = 1.
  - On valid & ready: capture oper/argA/argB, clear o_err, o_result and o_status, set step = 0, go to SETUP.
  - Requests are never accepted outside IDLE.
- SETUP (1 cycle): PSEL = 1, PENABLE = 0; PADDR, PWRITE and PWDATA driven for the current step (PWDATA = 0 on reads). Next state is ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1; address, control and data held stable.
  - PREADY is sampled on each edge and ignored outside ACCESS.
  - PREADY = 1 and PSLVERR = 0: the transfer completes. On a read, capture PRDATA (step 3 into o_result, step 4 PRDATA[3:0] into o_status).
    - After step 2: go to WAIT, or to SETUP of step 3 if EXE_LATENCY = 0.
    - After step 4: go to RESP.
    - Otherwise: go to SETUP of the next step, with PSEL staying 1 and PENABLE dropping to 0.
  - PREADY = 1 and PSLVERR = 1: set o_err, abort the remaining steps, go to RESP.
  - PREADY = 0 for TIMEOUT consecutive ACCESS cycles: set o_err, abort, go to RESP. The timeout counter clears on every SETUP.
- WAIT: PSEL = 0, PENABLE = 0 for exactly EXE_LATENCY cycles, then SETUP of step 3.
- Leaving ACCESS to WAIT or RESP drives PSEL = 0 and PENABLE = 0 on the same edge.
- RESP:
  - o_rsp_valid = 1; o_result, o_status and o_err held stable.
  - On i_rsp_ready = 1: o_rsp_valid drops and the state returns to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Aborted operation: o_result and o_status keep whatever was captured before the abort (0 if not reached).
- Latency with a slave that raises PREADY one cycle after PSEL & PENABLE (3 cycles per transfer): o_rsp_valid rises 15 + EXE_LATENCY edges after the accept edge, i.e. 17 at default parameters.
- Reset mid-operation: the APB bus is released immediately (PSEL = PENABLE = 0), any pending response is dropped, and the block returns to IDLE.

Test Plan:
- Write path and back-to-back SETUP: oper=3, argA=0x12, argB=0x05 against a model slave with one wait state. Required: write sequence (addr, data) = (0,3), (1,0x12), (2,0x05); PSEL stays high between transfers 0-1 and 1-2; exactly 2 idle cycles before the read at address 0.
- Read capture and latency: same operation; slave returns PRDATA 0x17 at address 0 and 0x0A at address 1. Required: o_rsp_valid rises 17 edges after accept, o_result = 0x17, o_status = 4'hA, o_err = 0.
- Slave wait states: slave inserts 5 wait states on the argA write. Required: address and data held throughout, no duplicate transfer, latency rises by 4 cycles.
- PSLVERR: PSLVERR asserted with PREADY on step 1. Required: no further APB transfers, o_rsp_valid with o_err = 1, o_result = 0, o_status = 0.
- Timeout: PREADY held low on step 3. Required: abort after 16 ACCESS cycles, PSEL drops on the same edge, o_err = 1.
- Back-pressure and reset: i_rsp_ready low for 10 cycles with i_req_valid high throughout. Required: outputs stable and o_req_ready = 0 until the handshake; then assert i_PRESETn low mid-ACCESS, required: PSEL and PENABLE fall immediately and o_req_ready = 1.

Source files
------------

// File: rtl/apb_exe_seq_master.sv
// APB master that runs one execution-unit operation: writes oper/argA/argB,
// waits a settle time, reads result and status, then returns a response.
module apb_exe_seq_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int EXE_LATENCY = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_oper,
  input  logic [DATA_WIDTH-1:0] i_argA,
  input  logic [DATA_WIDTH-1:0] i_argB,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [3:0]            o_status,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT);
  localparam int WW = (EXE_LATENCY > 32'sd1) ? $clog2(EXE_LATENCY) : 32'sd1;
  localparam bit HAS_WAIT = (EXE_LATENCY != 32'sd0);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 32'sd1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(HAS_WAIT ? EXE_LATENCY - 32'sd1 : 32'sd0);

  state_t                state_r, state_s;
  logic [2:0]            step_r, step_s, setup_step_s;
  logic [TW-1:0]         tmo_r, tmo_s;
  logic [WW-1:0]         wait_r, wait_s;
  logic [DATA_WIDTH-1:0] oper_r, oper_s, arga_r, arga_s, argb_r, argb_s;
  logic [ADDR_WIDTH-1:0] paddr_r, paddr_s;
  logic                  psel_r, psel_s, penable_r, penable_s, pwrite_r, pwrite_s;
  logic [DATA_WIDTH-1:0] pwdata_r, pwdata_s;
  logic                  req_ready_r, req_ready_s, rsp_valid_r, rsp_valid_s;
  logic [DATA_WIDTH-1:0] result_r, result_s;
  logic [3:0]            status_r, status_s;
  logic                  err_r, err_s;
  logic                  setup_s, finish_s;

  // Steps 0..2 write addresses 0..2; steps 3..4 read addresses 0..1.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [2:0] step);
    case (step)
      3'd1, 3'd4: step_addr = ADDR_WIDTH'(2'd1);
      3'd2:       step_addr = ADDR_WIDTH'(2'd2);
      default:    step_addr = {ADDR_WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] step_wdata(input logic [2:0] step,
                                                       input logic [DATA_WIDTH-1:0] op,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    case (step)
      3'd0:    step_wdata = op;
      3'd1:    step_wdata = a;
      3'd2:    step_wdata = b;
      default: step_wdata = {DATA_WIDTH{1'b0}};
    endcase
  endfunction

  // Next-state and next-output decode; every output register is loaded from here.
  always_comb begin
    state_s      = state_r;
    step_s       = step_r;
    tmo_s        = tmo_r;
    wait_s       = wait_r;
    oper_s       = oper_r;
    arga_s       = arga_r;
    argb_s       = argb_r;
    paddr_s      = paddr_r;
    psel_s       = psel_r;
    penable_s    = penable_r;
    pwrite_s     = pwrite_r;
    pwdata_s     = pwdata_r;
    req_ready_s  = req_ready_r;
    rsp_valid_s  = rsp_valid_r;
    result_s     = result_r;
    status_s     = status_r;
    err_s        = err_r;
    setup_s      = 1'b0;
    finish_s     = 1'b0;
    setup_step_s = step_r;

    case (state_r)
      IDLE: begin
        if (i_req_valid) begin
          oper_s       = i_oper;
          arga_s       = i_argA;
          argb_s       = i_argB;
          result_s     = {DATA_WIDTH{1'b0}};
          status_s     = 4'd0;
          err_s        = 1'b0;
          setup_s      = 1'b1;
          setup_step_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s   = ACCESS;
        penable_s = 1'b1;
        tmo_s     = {TW{1'b0}};
      end
      ACCESS: begin
        if (i_PREADY) begin
          if (i_PSLVERR) begin
            err_s    = 1'b1;
            finish_s = 1'b1;
          end else if (step_r == 3'd4) begin
            status_s = i_PRDATA[3:0];
            finish_s = 1'b1;
          end else if ((step_r == 3'd2) && HAS_WAIT) begin
            state_s   = WAIT;
            psel_s    = 1'b0;
            penable_s = 1'b0;
            wait_s    = {WW{1'b0}};
          end else begin
            if (step_r == 3'd3) begin
              result_s = i_PRDATA;
            end else begin
              result_s = result_r;
            end
            setup_s      = 1'b1;
            setup_step_s = step_r + 3'd1;
          end
        end else if (tmo_r == TMO_LAST) begin
          err_s    = 1'b1;
          finish_s = 1'b1;
        end else begin
          tmo_s = tmo_r + TW'(1'b1);
        end
      end
      WAIT: begin
        if (wait_r == WAIT_LAST) begin
          setup_s      = 1'b1;
          setup_step_s = 3'd3;
        end else begin
          wait_s = wait_r + WW'(1'b1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = IDLE;
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase

    // Bus is released on the same edge that leaves ACCESS for RESP.
    if (finish_s) begin
      state_s     = RESP;
      psel_s      = 1'b0;
      penable_s   = 1'b0;
      rsp_valid_s = 1'b1;
      req_ready_s = 1'b0;
    end else if (setup_s) begin
      state_s     = SETUP;
      step_s      = setup_step_s;
      psel_s      = 1'b1;
      penable_s   = 1'b0;
      paddr_s     = step_addr(setup_step_s);
      pwrite_s    = (setup_step_s < 3'd3);
      pwdata_s    = step_wdata(setup_step_s, oper_s, arga_s, argb_s);
      req_ready_s = 1'b0;
    end else begin
      req_ready_s = (state_s == IDLE);
    end
  end

  // State, operand and output registers.
  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_r     <= IDLE;
      step_r      <= 3'd0;
      tmo_r       <= {TW{1'b0}};
      wait_r      <= {WW{1'b0}};
      oper_r      <= {DATA_WIDTH{1'b0}};
      arga_r      <= {DATA_WIDTH{1'b0}};
      argb_r      <= {DATA_WIDTH{1'b0}};
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      pwdata_r    <= {DATA_WIDTH{1'b0}};
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      result_r    <= {DATA_WIDTH{1'b0}};
      status_r    <= 4'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      step_r      <= step_s;
      tmo_r       <= tmo_s;
      wait_r      <= wait_s;
      oper_r      <= oper_s;
      arga_r      <= arga_s;
      argb_r      <= argb_s;
      paddr_r     <= paddr_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
      pwrite_r    <= pwrite_s;
      pwdata_r    <= pwdata_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      result_r    <= result_s;
      status_r    <= status_s;
      err_r       <= err_s;
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_result    = result_r;
  assign o_status    = status_r;
  assign o_err       = err_r;
  assign o_PADDR     = paddr_r;
  assign o_PSEL      = psel_r;
  assign o_PENABLE   = penable_r;
  assign o_PWRITE    = pwrite_r;
  assign o_PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_exe_seq_master.sv
// Bench for apb_exe_seq_master: model slave, timeline model of the expected
// APB/response behaviour checked every cycle, plus literal pins per scenario.
module tb_apb_exe_seq_master;

  localparam int EXE = 2;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, rsp_ready = 1'b1;
  logic [7:0]  oper = 8'h00, arga = 8'h00, argb = 8'h00;
  logic        req_ready, rsp_valid, err, psel, penable, pwrite;
  logic [7:0]  result, pwdata;
  logic [3:0]  status;
  logic [15:0] paddr;
  logic        pready = 1'b0, pslverr = 1'b0;
  logic [7:0]  prdata = 8'h00;

  apb_exe_seq_master #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .EXE_LATENCY(EXE), .TIMEOUT(TMO)) dut (
    .i_PCLK(clk), .i_PRESETn(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_oper(oper), .i_argA(arga), .i_argB(argb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_result(result), .o_status(status), .o_err(err),
    .o_PADDR(paddr), .o_PSEL(psel), .o_PENABLE(penable), .o_PWRITE(pwrite), .o_PWDATA(pwdata),
    .i_PREADY(pready), .i_PRDATA(prdata), .i_PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  // slave configuration
  int         waits[5];
  int         err_step = -1, hang_step = -1;
  logic [7:0] rd_res = 8'h17, rd_sta = 8'h0A;

  // expected timeline of one operation
  int         s_at[5], acc[5];
  int         nst, lat;
  logic [15:0] e_addr[5];
  logic        e_wr[5];
  logic [7:0]  e_data[5];
  logic [7:0]  exp_res;
  logic [3:0]  exp_sta;
  logic        exp_err;

  bit         busy = 1'b0;
  int         rel = 0;
  bit         seen_rise = 1'b0;
  int         rise_rel = -1;
  logic [7:0] got_res;
  logic [3:0] got_sta;
  logic       got_err;
  logic [24:0] wlog[$];
  int         n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic set_cfg(input int w1, input int es, input int hs);
    for (int k = 0; k < 5; k++) waits[k] = 1;
    waits[1]  = w1;
    err_step  = es;
    hang_step = hs;
  endtask

  // Build the cycle timeline from the slave config: SETUP + ACCESS cycles per
  // step, the settle gap before step 3, and where an abort cuts it short.
  task automatic plan(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0; nst = 0; exp_res = 8'h00; exp_sta = 4'h0; exp_err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) t += EXE;
      s_at[k]   = t;
      acc[k]    = (hang_step == k) ? TMO : waits[k] + 1;
      e_addr[k] = 16'((k < 3) ? k : k - 3);
      e_wr[k]   = (k < 3);
      e_data[k] = (k == 0) ? op : (k == 1) ? a : (k == 2) ? b : 8'h00;
      nst = k + 1;
      t  += 1 + acc[k];
      if (hang_step == k || err_step == k) begin
        exp_err = 1'b1;
        break;
      end
      if (k == 3) exp_res = rd_res;
      if (k == 4) exp_sta = rd_sta[3:0];
    end
    lat = t;
  endtask

  // model slave: PREADY after waits[step] ACCESS cycles, decided on negedge
  initial begin
    int acnt, k;
    acnt = 0;
    forever begin
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
      if (psel && !penable) begin
        acnt = 0;
      end else if (psel && penable) begin
        k = pwrite ? int'(paddr) : int'(paddr) + 3;
        if (k >= 0 && k < 5 && hang_step != k && acnt >= waits[k]) begin
          pready  = 1'b1;
          pslverr = (err_step == k);
          prdata  = (paddr == 16'd0) ? rd_res : rd_sta;
        end
        acnt++;
      end
    end
  end

  // operation tracker: accept, edge count since accept, handshake
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy = 1'b0; rel = 0;
      end else begin
        if (psel && penable && pready) wlog.push_back({paddr, pwrite, pwdata});
        if (busy && rel >= lat && rsp_ready) busy = 1'b0;
        else if (busy) rel++;
        else if (req_valid) begin
          busy = 1'b1; rel = 0; seen_rise = 1'b0;
        end
      end
    end
  end

  // per-cycle compare against the timeline
  initial begin
    bit e_sel, e_en;
    int ek;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e_sel = 1'b0; e_en = 1'b0; ek = 0;
        if (busy) begin
          for (int k = 0; k < nst; k++) begin
            if (rel == s_at[k]) begin
              e_sel = 1'b1; ek = k;
            end else if (rel > s_at[k] && rel <= s_at[k] + acc[k]) begin
              e_sel = 1'b1; e_en = 1'b1; ek = k;
            end
          end
        end
        check("psel_penable", {psel, penable}, {e_sel, e_en});
        if (e_sel) check("apb_addr_dir_data", {paddr, pwrite, pwdata}, {e_addr[ek], e_wr[ek], e_data[ek]});
        check("req_ready", req_ready, !busy);
        check("rsp_valid", rsp_valid, busy && rel >= lat);
        if (busy && rel >= lat) check("rsp_payload", {result, status, err}, {exp_res, exp_sta, exp_err});
        if (busy && rsp_valid && !seen_rise) begin
          seen_rise = 1'b1; rise_rel = rel;
          got_res = result; got_sta = status; got_err = err;
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 20) begin @(negedge clk); n++; end
    if (!busy) bound_fail("accept_wait");
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!(busy && rel >= lat) && n < 400) begin @(negedge clk); n++; end
    if (!(busy && rel >= lat)) bound_fail("rsp_wait");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    if (busy) bound_fail("idle_wait");
  endtask

  task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    plan(op, a, b);
    wlog.delete();
    rise_rel = -1;
    oper = op; arga = a; argb = b; req_valid = 1'b1; rsp_ready = 1'b1;
    wait_accept();
    req_valid = 1'b0; oper = 8'hFF; arga = 8'hFF; argb = 8'hFF;
    wait_rsp();
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_cfg(1, -1, -1);
    plan(8'h00, 8'h00, 8'h00);
    #12;
    check("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 27'd0);
    check("reset_rsp", {rsp_valid, err, result, status}, 14'd0);
    check("reset_req_ready", req_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nominal operation, one slave wait state
    set_cfg(1, -1, -1);
    run_op(8'h03, 8'h12, 8'h05);
    check("model_lat_nominal", lat, 17);
    check("model_idle_gap", s_at[3] - (s_at[2] + 1 + acc[2]), EXE);
    check("nominal_latency", rise_rel, 17);
    check("nominal_result", got_res, 8'h17);
    check("nominal_status", got_sta, 4'hA);
    check("nominal_err", got_err, 1'b0);
    check("nominal_xfers", wlog.size(), 5);
    if (wlog.size() == 5) begin
      check("wr0", wlog[0], {16'd0, 1'b1, 8'h03});
      check("wr1", wlog[1], {16'd1, 1'b1, 8'h12});
      check("wr2", wlog[2], {16'd2, 1'b1, 8'h05});
      check("rd0", wlog[3], {16'd0, 1'b0, 8'h00});
      check("rd1", wlog[4], {16'd1, 1'b0, 8'h00});
    end

    // five wait states on the argA write
    set_cfg(5, -1, -1);
    run_op(8'hA5, 8'h3C, 8'h81);
    check("waits_latency", rise_rel, 21);
    check("waits_xfers", wlog.size(), 5);
    check("waits_result", {got_res, got_sta, got_err}, {8'h17, 4'hA, 1'b0});

    // slave error on step 1
    set_cfg(1, 1, -1);
    run_op(8'h44, 8'h55, 8'h66);
    check("slverr_latency", rise_rel, 6);
    check("slverr_xfers", wlog.size(), 2);
    check("slverr_rsp", {got_res, got_sta, got_err}, {8'h00, 4'h0, 1'b1});

    // PREADY stuck low on the result read
    set_cfg(1, -1, 3);
    run_op(8'h09, 8'h08, 8'h07);
    check("timeout_latency", rise_rel, 28);
    check("timeout_xfers", wlog.size(), 3);
    check("timeout_rsp", {got_res, got_sta, got_err}, {8'h00, 4'h0, 1'b1});

    // response back-pressure with a request held, then reset mid-ACCESS
    set_cfg(1, -1, -1);
    @(negedge clk);
    plan(8'h5A, 8'h11, 8'h22);
    oper = 8'h5A; arga = 8'h11; argb = 8'h22; req_valid = 1'b1; rsp_ready = 1'b0;
    wait_accept();
    wait_rsp();
    repeat (10) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_idle();
    begin
      int n;
      n = 0;
      while (!(busy && rel == 1) && n < 10) begin @(negedge clk); n++; end
      if (!(busy && rel == 1)) bound_fail("reaccept_wait");
    end
    check("pre_reset_access", {psel, penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_access_bus", {psel, penable}, 2'b00);
    check("reset_mid_access_req_ready", req_ready, 1'b1);
    check("reset_mid_access_rsp", rsp_valid, 1'b0);
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // recovery after reset
    set_cfg(1, -1, -1);
    run_op(8'h07, 8'h01, 8'h02);
    check("recover_latency", rise_rel, 17);
    check("recover_rsp", {got_res, got_sta, got_err}, {8'h17, 4'hA, 1'b0});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
